decode_ctrl_stage: RTL
======================

Name: decode_ctrl_stage

Overview:
- Registered RV32I decode/control stage with valid/ready handshake, flush and branch resolution.
- Sits between fetch and execute. Holds one decoded instruction and drives datapath select lines, ALU opcode and PC select.
- Generalises the single-cycle control decoder:
  - parametrised data width;
  - pipeline handshake;
  - illegal-instruction detection;
  - full branch-condition set including BGE/BGEU;
  - sticky fault status.

Parameters:
- XLEN, 32, instruction/PC width; must be 32 (instruction fields are fixed); kept for datapath consistency.
- ALU_SEL_W, 4, width of alu_sel; must be at least 4.
- RESET_PC_SEL, 0, value of pc_sel while no valid instruction is held.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch presents instr
- in_ready  out  1  stage can accept
- instr  in  XLEN  instruction word
- flush  in  1  discard held instruction (branch taken / trap)
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute consumes bundle
- br_eq  in  1  branch comparator equal, for the held instruction
- br_lt  in  1  branch comparator less-than, signedness per br_un
- reg_wen  out  1  register-file write enable
- imm_sel  out  3  0=I 1=S 2=B 3=U 4=J
- alu_src1  out  1  0=rs1 1=PC
- alu_src2  out  1  0=rs2 1=imm
- alu_sel  out  ALU_SEL_W  ALU operation
- br_un  out  1  unsigned compare
- mem_rw  out  1  1=store
- ld_u  out  1  unsigned load
- wb_sel  out  2  0=mem 1=alu 2=pc+4
- pc_sel  out  1  1=take branch/jump target
- illegal  out  1  held instruction is unsupported
- fault_sticky  out  1  set on the first accepted illegal instruction

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - out_valid=0; all control registers 0; fault_sticky=0.
  - pc_sel=RESET_PC_SEL, because out_valid=0.
- in_ready = !out_valid | out_ready. This is combinational; the stage accepts a new instruction in the same cycle the old one drains.
- Accept: in_valid & in_ready at a rising edge. The decoded bundle is registered and out_valid=1 on the next cycle. Latency is 1 cycle.
- Hold: out_valid & !out_ready keeps every output register stable. instr is ignored.
- Drain without refill: out_ready & !in_valid sets out_valid=0 next cycle.
- Flush:
  - Next cycle out_valid=0, regardless of in_valid, out_ready or an accept in the same cycle.
  - Flush has priority over accept.
  - fault_sticky is not set by an instruction accepted in the flush cycle.
- Decode, by opcode = instr[6:0] and f3 = instr[14:12]:
  - 0110011 R-type: reg_wen=1; alu_src2=0; alu_sel={instr[30],f3}; wb_sel=1.
  - 0010011 I-ALU: reg_wen=1; imm_sel=0; alu_src2=1; wb_sel=1; alu_sel={f3==101 ? instr[30] : 0, f3}.
  - 0000011 load: reg_wen=1; imm I; alu_src2=1; alu_sel=0000; ld_u=f3[2]; wb_sel=0.
  - 0100011 store: reg_wen=0; imm S; alu_src2=1; mem_rw=1; alu_sel=0000.
  - 1100011 branch: reg_wen=0; imm B; alu_src1=1; alu_src2=1; br_un=f3[1]; alu_sel=0000. f3 values 010 and 011 are illegal.
  - 1101111 JAL: reg_wen=1; imm J; alu_src1=1; alu_src2=1; wb_sel=2; jump.
  - 1100111 JALR: reg_wen=1; imm I; alu_src1=0; alu_src2=1; wb_sel=2; jump. f3 must be 000, otherwise illegal.
  - 0110111 LUI: reg_wen=1; imm U; alu_src2=1; alu_sel=1111 (pass B); wb_sel=1.
  - 0010111 AUIPC: reg_wen=1; imm U; alu_src1=1; alu_src2=1; alu_sel=0000; wb_sel=1.
  - Any other opcode, or instr[1:0] != 11: illegal=1. All writes are suppressed: reg_wen=0, mem_rw=0, no jump.
  - Unused fields are driven to 0, never X.
- Branch resolution (combinational from the held registers and br_eq/br_lt), taken per f3:
  - 000: br_eq
  - 001: !br_eq
  - 100 or 110: br_lt
  - 101 or 111: !br_lt
- pc_sel = out_valid & !illegal & (jump | branch & taken). When out_valid=0, pc_sel = RESET_PC_SEL.
- fault_sticky sets on an accepted illegal instruction and clears only on rst.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode constants;
  - imm_sel, wb_sel and alu_sel encodings;
  - ALU_SEL_W;
  - the control-bundle struct.
- One sub-module, rv_branch_cond: combinational (f3, br_eq, br_lt) -> taken. It is reusable by a future branch predictor.

Test Plan:
- rst asserted mid-stream with out_valid=1 -> out_valid=0, pc_sel=0, fault_sticky=0 immediately, without waiting for a clock edge.
- Accept 0x003100B3 (add) -> next cycle: out_valid=1, reg_wen=1, alu_sel=0000, wb_sel=1, alu_src2=0, illegal=0. Then 0x40000033 (sub) -> alu_sel=1000.
- Accept 0x40005013 (srai) -> alu_sel=1101, imm_sel=0, alu_src2=1. Then 0x00005013 (srli) -> alu_sel=0101.
- Accept 0x00000063 (beq):
  - br_eq=1 -> pc_sel=1;
  - br_eq=0 -> pc_sel=0.
  - Then 0x00007063 (bgeu) with br_lt=0 -> pc_sel=1 and br_un=1.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable. Then out_ready=1 -> the next instruction is accepted the same cycle, with no bubble.
- Accept 0x0000007F -> illegal=1, reg_wen=0, mem_rw=0, pc_sel=0, fault_sticky=1. Flush asserted in the same cycle as an accept -> out_valid=0 next cycle.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared RV32I control encodings, control bundle and decode function
package rv_ctrl_pkg;

  localparam int ALU_SEL_W = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4} imm_sel_e;
  typedef enum logic [1:0] {WB_MEM = 2'd0, WB_ALU = 2'd1, WB_PC4 = 2'd2} wb_sel_e;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_PASS_B = 4'b1111;

  typedef struct packed {
    logic       reg_wen;
    imm_sel_e   imm_sel;
    logic       alu_src1;
    logic       alu_src2;
    logic [3:0] alu_sel;
    logic       br_un;
    logic       mem_rw;
    logic       ld_u;
    wb_sel_e    wb_sel;
    logic       jump;
    logic       branch;
    logic [2:0] f3;
    logic       illegal;
  } ctrl_t;

  // Illegal encodings leave every field at zero so no write or redirect can leak out.
  function automatic ctrl_t decode(input logic [31:0] instr);
    ctrl_t c;
    logic [2:0] f3;
    f3 = instr[14:12];
    c = '0;
    if (instr[1:0] != 2'b11) begin
      c.illegal = 1'b1;
    end else begin
      case (instr[6:0])
        OP_R: begin
          c.reg_wen = 1'b1;
          c.alu_sel = {instr[30], f3};
          c.wb_sel  = WB_ALU;
        end
        OP_I: begin
          c.reg_wen  = 1'b1;
          c.imm_sel  = IMM_I;
          c.alu_src2 = 1'b1;
          c.alu_sel  = {(f3 == 3'b101) & instr[30], f3};
          c.wb_sel   = WB_ALU;
        end
        OP_LOAD: begin
          c.reg_wen  = 1'b1;
          c.imm_sel  = IMM_I;
          c.alu_src2 = 1'b1;
          c.alu_sel  = ALU_ADD;
          c.ld_u     = f3[2];
          c.wb_sel   = WB_MEM;
        end
        OP_STORE: begin
          c.imm_sel  = IMM_S;
          c.alu_src2 = 1'b1;
          c.mem_rw   = 1'b1;
          c.alu_sel  = ALU_ADD;
        end
        OP_BRANCH: begin
          if (f3[2:1] == 2'b01) begin
            c.illegal = 1'b1;
          end else begin
            c.imm_sel  = IMM_B;
            c.alu_src1 = 1'b1;
            c.alu_src2 = 1'b1;
            c.br_un    = f3[1];
            c.alu_sel  = ALU_ADD;
            c.branch   = 1'b1;
            c.f3       = f3;
          end
        end
        OP_JAL: begin
          c.reg_wen  = 1'b1;
          c.imm_sel  = IMM_J;
          c.alu_src1 = 1'b1;
          c.alu_src2 = 1'b1;
          c.wb_sel   = WB_PC4;
          c.jump     = 1'b1;
        end
        OP_JALR: begin
          if (f3 != 3'b000) begin
            c.illegal = 1'b1;
          end else begin
            c.reg_wen  = 1'b1;
            c.imm_sel  = IMM_I;
            c.alu_src2 = 1'b1;
            c.wb_sel   = WB_PC4;
            c.jump     = 1'b1;
          end
        end
        OP_LUI: begin
          c.reg_wen  = 1'b1;
          c.imm_sel  = IMM_U;
          c.alu_src2 = 1'b1;
          c.alu_sel  = ALU_PASS_B;
          c.wb_sel   = WB_ALU;
        end
        OP_AUIPC: begin
          c.reg_wen  = 1'b1;
          c.imm_sel  = IMM_U;
          c.alu_src1 = 1'b1;
          c.alu_src2 = 1'b1;
          c.alu_sel  = ALU_ADD;
          c.wb_sel   = WB_ALU;
        end
        default: c.illegal = 1'b1;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/rv_branch_cond.sv
// rtl/rv_branch_cond.sv - branch-taken evaluation from funct3 and comparator flags
module rv_branch_cond (
  input  logic [2:0] f3,
  input  logic       br_eq,
  input  logic       br_lt,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (f3)
      3'b000:         taken = br_eq;
      3'b001:         taken = !br_eq;
      3'b100, 3'b110: taken = br_lt;
      3'b101, 3'b111: taken = !br_lt;
      default:        taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// rtl/decode_ctrl_stage.sv - registered RV32I decode/control stage with handshake, flush and branch resolution
module decode_ctrl_stage #(
  parameter int   XLEN         = 32,
  parameter int   ALU_SEL_W    = 4,
  parameter logic RESET_PC_SEL = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      instr,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 br_eq,
  input  logic                 br_lt,
  output logic                 reg_wen,
  output logic [2:0]           imm_sel,
  output logic                 alu_src1,
  output logic                 alu_src2,
  output logic [ALU_SEL_W-1:0] alu_sel,
  output logic                 br_un,
  output logic                 mem_rw,
  output logic                 ld_u,
  output logic [1:0]           wb_sel,
  output logic                 pc_sel,
  output logic                 illegal,
  output logic                 fault_sticky
);
  import rv_ctrl_pkg::*;

  ctrl_t held;
  ctrl_t dec;
  logic  accept;
  logic  taken;

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign dec      = decode(instr);

  // Flush wins over an accept in the same cycle: nothing is loaded and no fault is recorded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      held         <= '0;
      fault_sticky <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      held      <= dec;
      if (dec.illegal) fault_sticky <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  rv_branch_cond u_branch_cond (
    .f3    (held.f3),
    .br_eq (br_eq),
    .br_lt (br_lt),
    .taken (taken)
  );

  assign pc_sel   = out_valid ? (!held.illegal & (held.jump | (held.branch & taken))) : RESET_PC_SEL;
  assign reg_wen  = held.reg_wen;
  assign imm_sel  = held.imm_sel;
  assign alu_src1 = held.alu_src1;
  assign alu_src2 = held.alu_src2;
  assign alu_sel  = ALU_SEL_W'(held.alu_sel);
  assign br_un    = held.br_un;
  assign mem_rw   = held.mem_rw;
  assign ld_u     = held.ld_u;
  assign wb_sel   = held.wb_sel;
  assign illegal  = held.illegal;

endmodule
